axis_pattern_gen: RTL and testbench

Parametrised AXI4-Stream master test-pattern source; successor to the free-running 8-bit stream counter. It adds a configurable data width, four pattern modes, packet framing with tlast, inter-packet gaps and a true valid/ready handshake. It drives the serdes/capture datapaths and their benches with known, self-checkable streams.

---
 rtl/axis_pg_pkg.sv | 19 +
 rtl/axis_pg_next_value.sv | 26 ++
 rtl/axis_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_axis_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pg_pkg.sv
// Shared encodings for the AXI4-Stream pattern generator.
package axis_pg_pkg;

    // Pattern modes as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_WALK = 2'd3
    } mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/axis_pg_next_value.sv
// Combinational pattern step: given the current beat value and mode,
// produce the value of the following beat (all arithmetic mod 2^DATA_W).
module axis_pg_next_value
    import axis_pg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] next_value
);

    // Select the step rule for the active mode.
    always_comb begin
        next_value = value;
        case (mode)
            MODE_INC:  next_value = value + DATA_W'(1);
            MODE_DEC:  next_value = value - DATA_W'(1);
            MODE_LFSR: next_value = (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
            MODE_WALK: next_value = {value[DATA_W-2:0], value[DATA_W-1]};
            default:   next_value = value;
        endcase
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream master test-pattern source: framed packets of a selectable
// pattern with tlast, optional idle gaps between packets, and a counter
// of completed packets.
module axis_pattern_gen
    import axis_pg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                PKT_LEN_W = 16,
    parameter int                GAP_W     = 8,
    parameter int                CNT_W     = 32,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
    input  logic                 clock,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    seed,
    input  logic [PKT_LEN_W-1:0] pkt_len,
    input  logic [GAP_W-1:0]     gap_len,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [DATA_W-1:0]    m_tdata,
    output logic                 m_tlast,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 busy
);

    state_e                state_q, state_d;
    logic [1:0]            mode_q;
    logic [PKT_LEN_W-1:0]  len_q;
    logic [GAP_W-1:0]      gap_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic [PKT_LEN_W-1:0]  beat_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     step_value;
    logic [DATA_W-1:0]     first_value;
    logic                  start_ok;
    logic                  last_beat;
    logic                  load;
    logic                  advance;
    logic                  gap_load;
    logic                  count_pkt;

    axis_pg_next_value #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_next (
        .mode       (mode_q),
        .value      (data_q),
        .next_value (step_value)
    );

    assign start_ok  = enable && (pkt_len != '0);
    assign last_beat = (beat_q == len_q);
    assign m_tvalid  = (state_q == ST_SEND);
    assign m_tlast   = m_tvalid && last_beat;
    assign m_tdata   = data_q;
    assign busy      = (state_q != ST_IDLE);

    // First beat of a packet: LFSR and walking-one cannot start from zero.
    always_comb begin
        first_value = seed;
        if (mode[1] && (seed == '0))
            first_value = DATA_W'(1);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decision and datapath control strobes.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        advance   = 1'b0;
        gap_load  = 1'b0;
        count_pkt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_tready) begin
                    if (last_beat) begin
                        count_pkt = 1'b1;
                        if (gap_q != '0) begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end else if (start_ok) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // Final gap cycle makes the same start decision as IDLE.
                if (gap_cnt == GAP_W'(1)) begin
                    if (start_ok) begin
                        load    = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet configuration latch, pattern value, beat and gap counters.
    always_ff @(posedge clock) begin
        if (!aresetn) begin
            mode_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            beat_q    <= '0;
            data_q    <= '0;
            pkt_count <= '0;
        end else begin
            if (load) begin
                mode_q <= mode;
                len_q  <= pkt_len;
                gap_q  <= gap_len;
                data_q <= first_value;
                beat_q <= PKT_LEN_W'(1);
            end else if (advance) begin
                data_q <= step_value;
                beat_q <= beat_q + PKT_LEN_W'(1);
            end
            if (gap_load)
                gap_cnt <= gap_q;
            else if (state_q == ST_GAP)
                gap_cnt <= gap_cnt - GAP_W'(1);
            if (count_pkt)
                pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: the stimulus side predicts every
// beat (data, tlast, preceding idle gap) into a queue; a monitor pops and
// compares on each transfer and checks hold-during-stall behaviour.
module tb_axis_pattern_gen;

    localparam int DATA_W    = 8;
    localparam int PKT_LEN_W = 4;
    localparam int GAP_W     = 3;
    localparam int CNT_W     = 3;

    logic                 clock;
    logic                 aresetn;
    logic                 enable;
    logic [1:0]           mode;
    logic [DATA_W-1:0]    seed;
    logic [PKT_LEN_W-1:0] pkt_len;
    logic [GAP_W-1:0]     gap_len;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [DATA_W-1:0]    m_tdata;
    logic                 m_tlast;
    logic [CNT_W-1:0]     pkt_count;
    logic                 busy;

    axis_pattern_gen #(
        .DATA_W    (DATA_W),
        .PKT_LEN_W (PKT_LEN_W),
        .GAP_W     (GAP_W),
        .CNT_W     (CNT_W),
        .LFSR_TAPS (8'hB8)
    ) dut (
        .clock     (clock),
        .aresetn   (aresetn),
        .enable    (enable),
        .mode      (mode),
        .seed      (seed),
        .pkt_len   (pkt_len),
        .gap_len   (gap_len),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       last;
        bit         first;
        int         gap;     // idle cycles expected before this beat, -1 = unchecked
    } beat_t;

    beat_t exp_q[$];
    int    checks     = 0;
    int    failures   = 0;
    int    total_pkts = 0;
    bit    sb_off     = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference pattern rules in plain integer arithmetic.
    function automatic logic [7:0] ref_next(input int m, input logic [7:0] v);
        int x = int'(v);
        int y;
        case (m)
            0:       y = (x + 1) % 256;
            1:       y = (x + 255) % 256;
            2: begin
                y = x / 2;
                if (x % 2 == 1) y = y ^ 'hB8;
            end
            default: y = (x * 2) % 256 + x / 128;
        endcase
        return 8'(y);
    endfunction

    function automatic logic [7:0] ref_first(input int m, input int s);
        if (m >= 2 && s == 0) return 8'd1;
        return 8'(s);
    endfunction

    task automatic push_packet(input int m, input int s, input int len, input int gap_before);
        logic [7:0] v;
        v = ref_first(m, s);
        for (int b = 1; b <= len; b++) begin
            exp_q.push_back('{data: v, last: (b == len), first: (b == 1),
                              gap: (b == 1) ? gap_before : -1});
            v = ref_next(m, v);
        end
    endtask

    // Monitor: sample 2 time units after the falling edge.
    initial begin
        bit         prev_stall = 0;
        logic [7:0] prev_data  = '0;
        logic       prev_last  = 0;
        int         idle_cnt   = 0;
        beat_t      it;
        forever begin
            @(negedge clock);
            #2;
            if (sb_off) begin
                prev_stall = 0;
                idle_cnt   = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(m_tvalid), 32'd1);
                    chk("stall_data", 32'(m_tdata), 32'(prev_data));
                    chk("stall_last", 32'(m_tlast), 32'(prev_last));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none t=%0t", m_tdata, $time);
                    end else begin
                        it = exp_q.pop_front();
                        if (it.first && it.gap >= 0) chk("gap_len", 32'(idle_cnt), 32'(it.gap));
                        chk("beat_data", 32'(m_tdata), 32'(it.data));
                        chk("beat_last", 32'(m_tlast), 32'(it.last));
                        if (m_tlast) idle_cnt = 0;
                    end
                end else if (!m_tvalid) begin
                    idle_cnt++;
                    if (exp_q.size() != 0 && exp_q[0].gap > 0)
                        chk("busy_in_gap", 32'(busy), 32'd1);
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    // One phase: k packets of a fixed configuration with enable held until
    // the k-th packet starts; rmode 0 = ready always, 1 = random, 2 = 1,0,0,1,1.
    task automatic run_phase(input int m, input int s, input int len, input int gap,
                             input int k, input int rmode);
        int  started = 0;
        int  vcyc    = 0;
        bit  in_pkt  = 0;
        bit  done    = 0;
        bit  r;
        bit  pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clock);
        mode    = 2'(m);
        seed    = 8'(s);
        pkt_len = PKT_LEN_W'(len);
        gap_len = GAP_W'(gap);
        for (int p = 0; p < k; p++) push_packet(m, s, len, (p == 0) ? -1 : gap);
        total_pkts += k;
        enable = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (m_tvalid && !in_pkt) begin
                started++;
                in_pkt = 1;
            end
            r = 1'b1;
            if (started > 0) begin
                if (rmode == 1)      r = ($urandom % 10) < 6;
                else if (rmode == 2) r = pat[vcyc % 5];
                vcyc++;
            end
            m_tready = r;
            if (m_tvalid && r && m_tlast) in_pkt = 0;
            if (started >= k && enable) begin
                // Scramble live inputs while the last packet is in flight.
                enable  = 1'b0;
                mode    = 2'($urandom_range(0, 3));
                seed    = 8'($urandom);
                pkt_len = PKT_LEN_W'($urandom);
                gap_len = GAP_W'($urandom);
            end
            if (started >= k && !busy && !m_tvalid && exp_q.size() == 0) done = 1;
        end
        enable = 1'b0;
        chk("phase_done", 32'(done), 32'd1);
        chk("pkt_count", 32'(pkt_count), 32'(total_pkts % 8));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        aresetn  = 1'b0;
        enable   = 1'b0;
        mode     = '0;
        seed     = '0;
        pkt_len  = '0;
        gap_len  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(m_tvalid), 32'd0);
        chk("rst_last", 32'(m_tlast), 32'd0);
        chk("rst_data", 32'(m_tdata), 32'd0);
        chk("rst_count", 32'(pkt_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        aresetn = 1'b1;
        sb_off  = 1'b0;

        // Increment wrap, back-to-back packets.
        run_phase(0, 'hFE, 4, 0, 3, 0);

        // Reset in the middle of a packet.
        @(negedge clock);
        mode = 2'd0; seed = 8'h30; pkt_len = 4'd10; gap_len = 3'd0;
        push_packet(0, 'h30, 10, -1);
        enable = 1'b1; m_tready = 1'b1;
        repeat (4) @(negedge clock);
        sb_off = 1'b1;
        exp_q.delete();
        aresetn = 1'b0;
        mode = 2'd3; seed = 8'h77; pkt_len = 4'd5;
        total_pkts = 0;
        @(negedge clock);
        chk("midrst_valid", 32'(m_tvalid), 32'd0);
        chk("midrst_last", 32'(m_tlast), 32'd0);
        chk("midrst_count", 32'(pkt_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        aresetn = 1'b1;
        sb_off  = 1'b0;
        run_phase(3, 'h77, 5, 0, 1, 0);

        // Decrement with stalls, LFSR from zero seed, walking one.
        run_phase(1, 'h01, 3, 0, 1, 2);
        run_phase(2, 'h00, 4, 0, 1, 0);
        run_phase(3, 'h40, 3, 0, 1, 0);
        run_phase(3, 'h00, 9, 0, 1, 1);
        // Gaps, maximum packet length, enable drop mid-packet.
        run_phase(0, 'h10, 2, 3, 3, 0);
        run_phase(2, 'hA5, 15, 7, 2, 1);
        run_phase(1, 'h00, 1, 0, 4, 0);
        run_phase(0, 'h55, 5, 0, 1, 0);

        // Zero length with enable never starts a packet.
        @(negedge clock);
        pkt_len = '0; gap_len = '0; enable = 1'b1; m_tready = 1'b1;
        repeat (12) begin
            @(negedge clock);
            chk("zero_len_valid", 32'(m_tvalid), 32'd0);
        end
        chk("zero_len_busy", 32'(busy), 32'd0);
        enable = 1'b0;

        // Randomized configurations.
        for (int i = 0; i < 14; i++)
            run_phase($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(1, 15),
                      $urandom_range(0, 7), $urandom_range(1, 4), $urandom_range(0, 1));

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
